// File: rtl/systolic_feed_ctrl.sv
// Skewed read scheduler for the systolic array's per-row input FIFOs.
// Row i streams len words starting i steps after row 0; any empty scheduled row stalls the whole wavefront.
module systolic_feed_ctrl #(
    parameter int ROWS = 3,
    parameter int KMAX = 16,
    localparam int LW = $clog2(KMAX + 1),
    localparam int TW = $clog2(KMAX + ROWS - 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LW-1:0]   len,
    input  logic [ROWS-1:0] fifo_empty,
    output logic [ROWS-1:0] fifo_ren,
    output logic [ROWS-1:0] valid_row,
    output logic            busy,
    output logic            done,
    output logic [7:0]      stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_d;
    logic [TW-1:0]   t;
    logic [LW-1:0]   len_q;
    logic [ROWS-1:0] sched;
    logic            stall;
    logic            last;

    always_comb begin
        sched    = '0;
        for (int i = 0; i < ROWS; i++)
            sched[i] = (int'(t) >= i) && (int'(t) < i + int'(len_q));
        stall    = |(sched & fifo_empty);
        last     = int'(t) == int'(len_q) + ROWS - 2;
        state_d  = state;
        fifo_ren = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_d = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                // A stall freezes every row so the diagonal skew survives.
                if (!stall) begin
                    fifo_ren = sched;
                    if (last)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            len_q     <= '0;
            stall_cnt <= '0;
            valid_row <= '0;
        end else begin
            state     <= state_d;
            valid_row <= fifo_ren;
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        len_q     <= (int'(len) > KMAX) ? LW'(KMAX) : len;
                        t         <= '0;
                        stall_cnt <= '0;
                    end
                end
                RUN: begin
                    if (stall) begin
                        if (stall_cnt != 8'hFF)
                            stall_cnt <= stall_cnt + 8'd1;
                    end else if (!last) begin
                        t <= t + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl (ROWS=3, KMAX=16).
// Cycle c is the interval after the c-th rising edge following the start cycle.
module tb_systolic_feed_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_ren;
    logic [2:0] valid_row;
    logic       busy;
    logic       done;
    logic [7:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    systolic_feed_ctrl #(.ROWS(3), .KMAX(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .valid_row(valid_row),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ren"}, 32'(fifo_ren), 0);
        chk({tag, ".valid"}, 32'(valid_row), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
    endtask

    // One len=4 job: fe = fifo_empty per cycle, er/ev = expected ren/valid per cycle.
    task automatic job4(input string tag, input logic [2:0] fe [10],
                        input logic [2:0] er [10], input logic [2:0] ev [10],
                        input int done_c, input int exp_stalls);
        nxt();
        start = 1'b1; len = 5'd4; fifo_empty = 3'b000;
        #1;
        chk({tag, ".c0.busy"}, 32'(busy), 0);
        for (int c = 1; c < 10; c++) begin
            nxt();
            start = 1'b0; fifo_empty = fe[c];
            #1;
            chk($sformatf("%s.c%0d.ren", tag, c), 32'(fifo_ren), 32'(er[c]));
            chk($sformatf("%s.c%0d.valid", tag, c), 32'(valid_row), 32'(ev[c]));
            chk($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'(c < done_c));
            chk($sformatf("%s.c%0d.done", tag, c), 32'(done), 32'(c == done_c));
        end
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stalls));
    endtask

    logic [2:0] fe_none  [10] = '{default: 3'b000};
    logic [2:0] er_nom   [10] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000};
    logic [2:0] ev_nom   [10] = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
    logic [2:0] fe_stall [10] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] er_stall [10] = '{3'b000, 3'b001, 3'b011, 3'b000, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
    logic [2:0] ev_stall [10] = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b000, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000};

    initial begin
        int cnt [3];
        int done_seen;

        rst = 1'b1; start = 1'b1; len = 5'd4; fifo_empty = 3'b000;

        // Reset held 3 cycles with start high and arbitrary empties.
        for (int c = 0; c < 3; c++) begin
            nxt();
            fifo_empty = 3'($urandom);
            #1;
            chk_idle($sformatf("rst.c%0d", c));
            chk($sformatf("rst.c%0d.stall", c), 32'(stall_cnt), 0);
        end
        nxt();
        rst = 1'b0; start = 1'b0; fifo_empty = 3'b000;
        #1;
        chk_idle("rst.rel");
        chk("rst.rel.stall", 32'(stall_cnt), 0);

        job4("nom", fe_none, er_nom, ev_nom, 8, 0);
        job4("stall", fe_stall, er_stall, ev_stall, 9, 1);

        // len=0 finishes immediately with no reads.
        nxt();
        start = 1'b1; len = 5'd0;
        #1;
        nxt();
        start = 1'b0;
        #1;
        chk("len0.c1.done", 32'(done), 1);
        chk("len0.c1.ren", 32'(fifo_ren), 0);
        chk("len0.c1.busy", 32'(busy), 0);
        nxt();
        #1;
        chk_idle("len0.c2");

        // len=31 clamps to 16 reads per row; done lands in cycle 20.
        nxt();
        start = 1'b1; len = 5'd31;
        #1;
        cnt = '{0, 0, 0};
        done_seen = 0;
        for (int c = 1; c <= 22; c++) begin
            nxt();
            start = 1'b0;
            #1;
            for (int r = 0; r < 3; r++) cnt[r] += int'(fifo_ren[r]);
            if (c == 1) chk("len31.c1.ren", 32'(fifo_ren), 32'b001);
            if (done) done_seen = c;
        end
        for (int r = 0; r < 3; r++)
            chk($sformatf("len31.row%0d.reads", r), 32'(cnt[r]), 16);
        chk("len31.done_cycle", 32'(done_seen), 20);

        // start pulses in cycles 3 and 8 of a len=4 job are ignored.
        nxt();
        start = 1'b1; len = 5'd4;
        #1;
        done_seen = 0;
        for (int c = 1; c <= 16; c++) begin
            nxt();
            start = (c == 3 || c == 8);
            #1;
            if (done) done_seen++;
            if (c > 8) chk($sformatf("ign.c%0d.busy", c), 32'(busy), 0);
        end
        chk("ign.done_count", 32'(done_seen), 1);

        // Abort with reset in cycle 4.
        nxt();
        start = 1'b1; len = 5'd4;
        #1;
        for (int c = 1; c <= 3; c++) begin
            nxt();
            start = 1'b0;
            #1;
        end
        nxt();
        rst = 1'b1;
        #1;
        nxt();
        rst = 1'b0;
        #1;
        chk_idle("abort.c5");
        chk("abort.c5.stall", 32'(stall_cnt), 0);
        done_seen = 0;
        for (int c = 6; c <= 12; c++) begin
            nxt();
            #1;
            if (done || busy || fifo_ren != 3'b000) done_seen++;
        end
        chk("abort.quiet", 32'(done_seen), 0);

        job4("post", fe_none, er_nom, ev_nom, 8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
